// File: rtl/core_pkg.sv
// Shared core definitions: writeback source encoding and the GPIO CSR addresses.
package core_pkg;

  typedef enum logic [1:0] {
    REGSEL_CSR = 2'b00,
    REGSEL_LUI = 2'b01,
    REGSEL_ALU = 2'b10,
    REGSEL_RSV = 2'b11
  } regsel_t;

  localparam logic [11:0] CSR_IO0_IN  = 12'hF00;
  localparam logic [11:0] CSR_IO2_OUT = 12'hF02;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for the asynchronous switch inputs.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register and writeback stage: WB data select, WB->EX forwarding,
// and the GPIO output (HEX) register.
module ex_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite_EX,
  input  logic [1:0]      regsel_EX,
  input  logic            gpio_we,
  input  logic            flush_EX,
  input  logic [4:0]      rd_EX,
  input  logic [4:0]      rs1_EX,
  input  logic [4:0]      rs2_EX,
  input  logic [XLEN-1:0] alu_result_EX,
  input  logic [19:0]     imm_u_EX,
  input  logic [XLEN-1:0] readdata1_EX,
  input  logic [XLEN-1:0] readdata2_EX,
  input  logic [XLEN-1:0] gpio_in,
  output logic            regwrite_WB,
  output logic [4:0]      writeaddr_WB,
  output logic [XLEN-1:0] writedata_WB,
  output logic [XLEN-1:0] fwd_data1_EX,
  output logic [XLEN-1:0] fwd_data2_EX,
  output logic [XLEN-1:0] gpio_out
);

  logic [XLEN-1:0] w_gpio_sync;
  logic [XLEN-1:0] w_wdata;

  logic            r_regwrite;
  regsel_t         r_regsel;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu;
  logic [19:0]     r_imm_u;
  logic [XLEN-1:0] r_gpio_sync;

  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(XLEN)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (gpio_in),
    .o_q (w_gpio_sync)
  );

  // case-based capture so an undecoded (X) control word lands as 0, not X
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regwrite  <= 1'b0;
      r_regsel    <= REGSEL_CSR;
      r_rd        <= '0;
      r_alu       <= '0;
      r_imm_u     <= '0;
      r_gpio_sync <= '0;
      gpio_out    <= '0;
    end else begin
      case (regwrite_EX)
        1'b1:    r_regwrite <= ~flush_EX;
        default: r_regwrite <= 1'b0;
      endcase
      case (regsel_EX)
        2'b01:   r_regsel <= REGSEL_LUI;
        2'b10:   r_regsel <= REGSEL_ALU;
        2'b11:   r_regsel <= REGSEL_RSV;
        default: r_regsel <= REGSEL_CSR;
      endcase
      r_rd        <= rd_EX;
      r_alu       <= alu_result_EX;
      r_imm_u     <= imm_u_EX;
      r_gpio_sync <= w_gpio_sync;
      if (gpio_we && !flush_EX) gpio_out <= readdata1_EX;
    end
  end

  always_comb begin
    w_wdata = r_alu;
    case (r_regsel)
      REGSEL_LUI: w_wdata = XLEN'({r_imm_u, 12'b0});
      REGSEL_CSR: w_wdata = r_gpio_sync;
      default:    w_wdata = r_alu;
    endcase
  end

  assign regwrite_WB  = r_regwrite && (r_rd != 5'd0);
  assign writeaddr_WB = r_rd;
  assign writedata_WB = w_wdata;

  assign fwd_data1_EX = (regwrite_WB && (writeaddr_WB == rs1_EX)) ? writedata_WB : readdata1_EX;
  assign fwd_data2_EX = (regwrite_WB && (writeaddr_WB == rs2_EX)) ? writedata_WB : readdata2_EX;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Self-checking bench for ex_wb_stage: delay-line reference model plus directed literal checks.
module tb_ex_wb_stage;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwrite_EX, gpio_we, flush_EX;
  logic [1:0]  regsel_EX;
  logic [4:0]  rd_EX, rs1_EX, rs2_EX;
  logic [31:0] alu_result_EX, readdata1_EX, readdata2_EX, gpio_in;
  logic [19:0] imm_u_EX;
  logic        regwrite_WB;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB, fwd_data1_EX, fwd_data2_EX, gpio_out;

  int errors = 0;
  int checks = 0;

  ex_wb_stage #(.XLEN(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .regwrite_EX(regwrite_EX), .regsel_EX(regsel_EX), .gpio_we(gpio_we), .flush_EX(flush_EX),
    .rd_EX(rd_EX), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .alu_result_EX(alu_result_EX), .imm_u_EX(imm_u_EX),
    .readdata1_EX(readdata1_EX), .readdata2_EX(readdata2_EX), .gpio_in(gpio_in),
    .regwrite_WB(regwrite_WB), .writeaddr_WB(writeaddr_WB), .writedata_WB(writedata_WB),
    .fwd_data1_EX(fwd_data1_EX), .fwd_data2_EX(fwd_data2_EX), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what WB must hold after each edge, and a delay line for the switches.
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_gpio;
  logic [31:0] hist[$];

  always @(posedge clk or posedge rst) begin
    logic [31:0] sw;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(32'h0);
      m_we   <= 1'b0;
      m_addr <= 5'd0;
      m_data <= 32'h0;
      m_gpio <= 32'h0;
    end else begin
      sw = hist.pop_back();
      hist.push_front(gpio_in);
      m_we   <= regwrite_EX && !flush_EX && (rd_EX != 5'd0);
      m_addr <= rd_EX;
      if (regsel_EX == 2'b01)      m_data <= {imm_u_EX, 12'h000};
      else if (regsel_EX == 2'b00) m_data <= sw;
      else                         m_data <= alu_result_EX;
      if (gpio_we && !flush_EX) m_gpio <= readdata1_EX;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model regwrite_WB", {31'b0, regwrite_WB}, {31'b0, m_we});
      check("model writeaddr_WB", {27'b0, writeaddr_WB}, {27'b0, m_addr});
      check("model writedata_WB", writedata_WB, m_data);
      check("model gpio_out", gpio_out, m_gpio);
      check("model fwd1", fwd_data1_EX, (m_we && m_addr == rs1_EX) ? m_data : readdata1_EX);
      check("model fwd2", fwd_data2_EX, (m_we && m_addr == rs2_EX) ? m_data : readdata2_EX);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic rw, input logic [1:0] sel, input logic we, input logic fl,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [19:0] imm,
                       input logic [31:0] rd1);
    regwrite_EX = rw; regsel_EX = sel; gpio_we = we; flush_EX = fl;
    rd_EX = rd; alu_result_EX = alu; imm_u_EX = imm; readdata1_EX = rd1;
  endtask

  typedef struct {
    logic rw; logic [1:0] sel; logic we; logic fl; logic [4:0] rd, rs1, rs2;
    logic [31:0] alu; logic [19:0] imm; logic [31:0] rd1, rd2, gin;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0);
    rs1_EX = 5'd0; rs2_EX = 5'd0; readdata2_EX = 32'h0; gpio_in = 32'h0;
    cyc(); cyc();
    check("reset regwrite_WB", {31'b0, regwrite_WB}, 32'h0);
    check("reset gpio_out", gpio_out, 32'h0);
    rst = 1'b0;

    // ALU writeback
    drive(1'b1, 2'b10, 1'b0, 1'b0, 5'd5, 32'h0000_002A, 20'h0, 32'h0);
    cyc();
    check("alu regwrite", {31'b0, regwrite_WB}, 32'h1);
    check("alu addr", {27'b0, writeaddr_WB}, 32'd5);
    check("alu data", writedata_WB, 32'h0000_002A);

    // LUI, then LUI to x0
    drive(1'b1, 2'b01, 1'b0, 1'b0, 5'd3, 32'h0, 20'h12345, 32'h0);
    cyc();
    check("lui data", writedata_WB, 32'h1234_5000);
    check("lui regwrite", {31'b0, regwrite_WB}, 32'h1);
    rd_EX = 5'd0;
    cyc();
    check("lui x0 regwrite", {31'b0, regwrite_WB}, 32'h0);

    // Switch read through the synchronizer
    drive(1'b1, 2'b00, 1'b0, 1'b0, 5'd9, 32'h0, 20'h0, 32'h0);
    gpio_in = 32'h0003_FFFF;
    cyc();
    check("switch edge1", writedata_WB, 32'h0);
    cyc();
    check("switch edge2", writedata_WB, 32'h0);
    cyc();
    check("switch edge3", writedata_WB, 32'h0003_FFFF);

    // Forwarding from WB
    drive(1'b1, 2'b10, 1'b0, 1'b0, 5'd7, 32'hDEAD_BEEF, 20'h0, 32'h1111_1111);
    cyc();
    rs1_EX = 5'd7; rs2_EX = 5'd8; readdata2_EX = 32'h2222_2222;
    regwrite_EX = 1'b0;
    #1;
    check("fwd1 hit", fwd_data1_EX, 32'hDEAD_BEEF);
    check("fwd2 miss", fwd_data2_EX, 32'h2222_2222);

    // GPIO write, then flushed GPIO write
    drive(1'b0, 2'b10, 1'b1, 1'b0, 5'd4, 32'h0, 20'h0, 32'h0000_1234);
    cyc();
    check("gpio write", gpio_out, 32'h0000_1234);
    drive(1'b1, 2'b10, 1'b1, 1'b1, 5'd4, 32'h55, 20'h0, 32'h0000_5678);
    cyc();
    check("gpio flush hold", gpio_out, 32'h0000_1234);
    check("flush regwrite", {31'b0, regwrite_WB}, 32'h0);

    // WB write to rs1 with gpio_we: gpio_out takes raw readdata1
    drive(1'b1, 2'b10, 1'b0, 1'b0, 5'd7, 32'h0000_AAAA, 20'h0, 32'h0);
    cyc();
    drive(1'b0, 2'b10, 1'b1, 1'b0, 5'd0, 32'h0, 20'h0, 32'h0000_BBBB);
    rs1_EX = 5'd7;
    cyc();
    check("gpio raw rs1", gpio_out, 32'h0000_BBBB);

    // Reserved regsel selects ALU result
    drive(1'b1, 2'b11, 1'b0, 1'b0, 5'd12, 32'hCAFE_F00D, 20'hFFFFF, 32'h0);
    cyc();
    check("regsel 11", writedata_WB, 32'hCAFE_F00D);

    // Directed vector table, checked by the model every cycle
    vecs.push_back('{1'b1, 2'b10, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2, 32'h0000_0010, 20'h0, 32'hA1, 32'hA2, 32'h0000_0F0F});
    vecs.push_back('{1'b1, 2'b01, 1'b1, 1'b0, 5'd2, 5'd1, 5'd2, 32'h0000_0020, 20'hABCDE, 32'hB1, 32'hB2, 32'h0000_0F0F});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 5'd3, 5'd2, 5'd3, 32'h0000_0030, 20'h0, 32'hC1, 32'hC2, 32'h1234_0000});
    vecs.push_back('{1'b1, 2'b00, 1'b1, 1'b1, 5'd4, 5'd3, 5'd4, 32'h0000_0040, 20'h0, 32'hD1, 32'hD2, 32'h1234_0000});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 1'b0, 5'd5, 5'd4, 5'd5, 32'h0000_0050, 20'h0, 32'hE1, 32'hE2, 32'h8000_0001});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 1'b0, 5'd31, 5'd5, 5'd31, 32'h0000_0060, 20'h0, 32'hF1, 32'hF2, 32'h8000_0001});
    vecs.push_back('{1'b1, 2'b11, 1'b1, 1'b0, 5'd0, 5'd31, 5'd0, 32'h0000_0070, 20'h0, 32'h91, 32'h92, 32'h0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 1'b0, 5'd6, 5'd0, 5'd6, 32'h0000_0080, 20'h00001, 32'h81, 32'h82, 32'h0});
    foreach (vecs[i]) begin
      drive(vecs[i].rw, vecs[i].sel, vecs[i].we, vecs[i].fl, vecs[i].rd, vecs[i].alu, vecs[i].imm, vecs[i].rd1);
      rs1_EX = vecs[i].rs1; rs2_EX = vecs[i].rs2; readdata2_EX = vecs[i].rd2; gpio_in = vecs[i].gin;
      cyc();
    end
    cyc();

    // Reset in the middle of a cycle clears outputs without an edge
    drive(1'b1, 2'b10, 1'b1, 1'b0, 5'd9, 32'h0000_0777, 20'h0, 32'h0000_0999);
    cyc();
    check("pre-reset gpio", gpio_out, 32'h0000_0999);
    #1 rst = 1'b1;
    #1;
    check("async reset gpio_out", gpio_out, 32'h0);
    check("async reset regwrite", {31'b0, regwrite_WB}, 32'h0);
    check("async reset writedata", writedata_WB, 32'h0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
